// File: rtl/stream_seq_checker.sv
// Stream sequence checker: locks onto a modulo-2^WIDTH incrementing stream,
// counts sequence errors and drops lock after LOSS_THRESH consecutive misses.
module stream_seq_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count,
    output logic [WIDTH-1:0] expected
);

    localparam int unsigned MISS_W = 4;
    localparam logic [MISS_W-1:0] LOSS_LIM = MISS_W'(LOSS_THRESH);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [MISS_W-1:0] miss_run;
    logic [WIDTH-1:0]  seed;
    logic              sample_hit;
    logic [MISS_W-1:0] miss_next;

    assign seed       = in_data + WIDTH'(1);
    assign sample_hit = (in_data == expected);
    assign miss_next  = miss_run + MISS_W'(1);

    // Any accepted sample resyncs expected to sample+1; on a match that equals expected+1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= HUNT;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
            expected     <= '0;
            miss_run     <= '0;
        end else if (clear) begin
            state        <= HUNT;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
            expected     <= '0;
            miss_run     <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                if (sample_count != {CNT_W{1'b1}}) begin
                    sample_count <= sample_count + CNT_W'(1);
                end
                expected <= seed;
                case (state)
                    HUNT: begin
                        state <= VERIFY;
                    end
                    VERIFY: begin
                        if (sample_hit) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            miss_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (sample_hit) begin
                            miss_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != {CNT_W{1'b1}}) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (miss_next == LOSS_LIM) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                miss_run <= '0;
                            end else begin
                                miss_run <= miss_next;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
